// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux : N-digit multiplexed 7-segment driver with PWM, LZB, snapshot
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1250,
  parameter int BRIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb,
  input  logic                  en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0]    c_PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]    c_IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] c_PH_MAX  = '1;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [BRIGHT_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_snap_q, blank_q;
  logic                lzb_q;

  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_q;

  logic                w_start;
  logic [4*DIGITS-1:0] w_data;
  logic [DIGITS-1:0]   w_dp, w_blank, w_supp;
  logic                w_lzb, w_run;
  logic [3:0]          w_nib;
  logic                w_dp_sel, w_blank_sel, w_supp_sel;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      default: hex2seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    phase_d   = phase_q;
    idx_d     = idx_q;
    if (pre_cnt_q == c_PRE_MAX) begin
      pre_cnt_d = '0;
      phase_d   = phase_q + 1'b1;
      if (phase_q == c_PH_MAX)
        idx_d = (idx_q == c_IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // On a frame-start edge the fresh inputs bypass the snapshot so the first
  // slot of a frame never mixes old and new values.
  assign w_start = (pre_cnt_q == '0) && (phase_q == '0) && (idx_q == '0);
  assign w_data  = w_start ? data  : data_q;
  assign w_dp    = w_start ? dp_in : dp_snap_q;
  assign w_blank = w_start ? blank : blank_q;
  assign w_lzb   = w_start ? lzb   : lzb_q;

  always_comb begin
    w_supp = '0;
    w_run  = w_lzb;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_run     = w_run & (w_data[4*i +: 4] == 4'h0);
      w_supp[i] = w_run;
    end
  end

  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b1;
    w_supp_sel  = 1'b0;
    anode_d     = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_nib       = w_data[4*i +: 4];
        w_dp_sel    = w_dp[i];
        w_blank_sel = w_blank[i];
        w_supp_sel  = w_supp[i];
        if (en && (phase_q <= bright) && !w_blank[i])
          anode_d[i] = 1'b0;
      end
    end
    seg_d = (w_blank_sel || w_supp_sel) ? 7'h7F : hex2seg(w_nib);
    dp_d  = w_blank_sel ? 1'b1 : ~w_dp_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      phase_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      dp_snap_q <= '0;
      blank_q   <= '1;
      lzb_q     <= 1'b0;
      anode_q   <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      if (w_start) begin
        data_q    <= data;
        dp_snap_q <= dp_in;
        blank_q   <= blank;
        lzb_q     <= lzb;
      end
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= w_start;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux : directed self-checking bench for seg7_scan_mux
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_mux;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 2;
  localparam int BRIGHT_W = 2;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SC   = 7'b1000110;
  localparam logic [6:0] SF   = 7'b0001110;
  localparam logic [6:0] SOFF = 7'h7F;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank;
  logic                  lzb;
  logic                  en;
  logic [BRIGHT_W-1:0]   bright;
  logic [DIGITS-1:0]     anode;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame;

  int checks = 0;
  int errors = 0;

  seg7_scan_mux #(
    .DIGITS(DIGITS),
    .PRESCALE(PRESCALE),
    .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .dp_in(dp_in),
    .blank(blank),
    .lzb(lzb),
    .en(en),
    .bright(bright),
    .anode(anode),
    .seg(seg),
    .dp(dp),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es,
                     input logic ed, input logic ef);
    checks++;
    assert (anode === ea) else begin
      errors++;
      $error("FAIL %s anode got %b exp %b", tag, anode, ea);
    end
    checks++;
    assert (seg === es) else begin
      errors++;
      $error("FAIL %s seg got %b exp %b", tag, seg, es);
    end
    checks++;
    assert (dp === ed) else begin
      errors++;
      $error("FAIL %s dp got %b exp %b", tag, dp, ed);
    end
    checks++;
    assert (frame === ef) else begin
      errors++;
      $error("FAIL %s frame got %b exp %b", tag, frame, ef);
    end
  endtask

  // One 8-cycle digit slot: anode low for the first 'on' cycles.
  task automatic slot(input string tag, input int d, input int on, input logic [6:0] es,
                      input logic ed, input logic fr);
    logic [3:0] ea;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ea = 4'b0001 << d;
      ea = (c < on) ? ~ea : 4'hF;
      chk(tag, ea, es, ed, fr && (c == 0));
    end
  endtask

  initial begin
    rst    = 1'b1;
    data   = 16'h1A08;
    dp_in  = 4'b0000;
    blank  = 4'b0000;
    lzb    = 1'b0;
    en     = 1'b1;
    bright = 2'd3;
    repeat (3) begin
      @(negedge clk);
      chk("reset", 4'hF, SOFF, 1'b1, 1'b0);
    end
    rst = 1'b0;

    // scan order, two full frames at full brightness
    repeat (2) begin
      slot("scan_d0", 0, 8, S8, 1'b1, 1'b1);
      slot("scan_d1", 1, 8, S0, 1'b1, 1'b0);
      slot("scan_d2", 2, 8, SA, 1'b1, 1'b0);
      slot("scan_d3", 3, 8, S1, 1'b1, 1'b0);
    end

    bright = 2'd1;
    slot("bright1_d0", 0, 4, S8, 1'b1, 1'b1);
    slot("bright1_d1", 1, 4, S0, 1'b1, 1'b0);
    slot("bright1_d2", 2, 4, SA, 1'b1, 1'b0);
    slot("bright1_d3", 3, 4, S1, 1'b1, 1'b0);

    bright = 2'd0;
    slot("bright0_d0", 0, 2, S8, 1'b1, 1'b1);
    slot("bright0_d1", 1, 2, S0, 1'b1, 1'b0);
    slot("bright0_d2", 2, 2, SA, 1'b1, 1'b0);
    slot("bright0_d3", 3, 2, S1, 1'b1, 1'b0);

    bright = 2'd3;
    data   = 16'h0050;
    lzb    = 1'b1;
    dp_in  = 4'b1000;
    slot("lzb_d0", 0, 8, S0,   1'b1, 1'b1);
    slot("lzb_d1", 1, 8, S5,   1'b1, 1'b0);
    slot("lzb_d2", 2, 8, SOFF, 1'b1, 1'b0);
    slot("lzb_d3", 3, 8, SOFF, 1'b0, 1'b0);

    data  = 16'h0000;
    dp_in = 4'b0000;
    slot("lzb0_d0", 0, 8, S0,   1'b1, 1'b1);
    slot("lzb0_d1", 1, 8, SOFF, 1'b1, 1'b0);
    slot("lzb0_d2", 2, 8, SOFF, 1'b1, 1'b0);
    slot("lzb0_d3", 3, 8, SOFF, 1'b1, 1'b0);

    lzb  = 1'b0;
    data = 16'h1111;
    slot("snap_d0", 0, 8, S1, 1'b1, 1'b1);
    data = 16'h2222;
    slot("snap_d1", 1, 8, S1, 1'b1, 1'b0);
    slot("snap_d2", 2, 8, S1, 1'b1, 1'b0);
    slot("snap_d3", 3, 8, S1, 1'b1, 1'b0);
    slot("snapnew_d0", 0, 8, S2, 1'b1, 1'b1);
    slot("snapnew_d1", 1, 8, S2, 1'b1, 1'b0);
    slot("snapnew_d2", 2, 8, S2, 1'b1, 1'b0);
    slot("snapnew_d3", 3, 8, S2, 1'b1, 1'b0);

    blank = 4'b0010;
    dp_in = 4'b0010;
    slot("blank_d0", 0, 8, S2,   1'b1, 1'b1);
    slot("blank_d1", 1, 0, SOFF, 1'b1, 1'b0);
    slot("blank_d2", 2, 8, S2,   1'b1, 1'b0);
    slot("blank_d3", 3, 8, S2,   1'b1, 1'b0);

    blank = 4'b0000;
    dp_in = 4'b0000;
    en    = 1'b0;
    repeat (2) begin
      slot("en0_d0", 0, 0, S2, 1'b1, 1'b1);
      slot("en0_d1", 1, 0, S2, 1'b1, 1'b0);
      slot("en0_d2", 2, 0, S2, 1'b1, 1'b0);
      slot("en0_d3", 3, 0, S2, 1'b1, 1'b0);
    end

    en = 1'b1;
    slot("pre_rst_d0", 0, 8, S2, 1'b1, 1'b1);
    slot("pre_rst_d1", 1, 8, S2, 1'b1, 1'b0);
    data = 16'h3C5F;
    repeat (3) begin
      @(negedge clk);
      chk("pre_rst_d2", 4'b1011, S2, 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", 4'hF, SOFF, 1'b1, 1'b0);
    rst = 1'b0;
    slot("post_rst_d0", 0, 8, SF, 1'b1, 1'b1);
    slot("post_rst_d1", 1, 8, S5, 1'b1, 1'b0);
    slot("post_rst_d2", 2, 8, SC, 1'b1, 1'b0);
    slot("post_rst_d3", 3, 8, S3, 1'b1, 1'b0);
    slot("post_rst_next", 0, 8, SF, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
